// File: rtl/clk_rst_gen.sv
// Multi-channel clock divider and staggered reset sequencer.
// One reference clock in; NUM_CH gated, divided clocks and per-channel active-low resets out.
module clk_rst_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int HOLD_CYC    = 16,
    parameter int STAGGER_CYC = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [NUM_CH-1:0]       clk_en_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic                    srst_req_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       rst_n_o,
    output logic                    ready_o
);

    localparam int HCW = $clog2(HOLD_CYC + 1);
    localparam int SCW = $clog2(STAGGER_CYC + 1);
    localparam int ICW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_ok;
    state_t                 state;
    logic [HCW-1:0]         hold_cnt;
    logic [SCW-1:0]         stg_cnt;
    logic [ICW-1:0]         rel_idx;
    logic                   srst_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

    // Hold counting begins the edge after both the synchroniser reads 1 and the
    // soft request was last sampled low, so both restart paths share one origin.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= HOLD;
            hold_cnt <= '0;
            stg_cnt  <= '0;
            rel_idx  <= '0;
            rst_n_o  <= '0;
            ready_o  <= 1'b0;
            srst_q   <= 1'b0;
        end else begin
            srst_q <= srst_req_i;
            if (srst_req_i) begin
                state    <= HOLD;
                hold_cnt <= '0;
                stg_cnt  <= '0;
                rel_idx  <= '0;
                rst_n_o  <= '0;
                ready_o  <= 1'b0;
            end else begin
                case (state)
                    HOLD: begin
                        if (sync_ok && !srst_q) begin
                            if (hold_cnt == HCW'(HOLD_CYC - 1)) begin
                                hold_cnt   <= '0;
                                stg_cnt    <= '0;
                                rst_n_o[0] <= 1'b1;
                                if (NUM_CH == 1) begin
                                    state <= RUN;
                                end else begin
                                    state   <= RELEASE;
                                    rel_idx <= ICW'(1);
                                end
                            end else begin
                                hold_cnt <= hold_cnt + HCW'(1);
                            end
                        end
                    end
                    RELEASE: begin
                        if (stg_cnt == SCW'(STAGGER_CYC - 1)) begin
                            stg_cnt          <= '0;
                            rst_n_o[rel_idx] <= 1'b1;
                            if (rel_idx == ICW'(NUM_CH - 1)) begin
                                state <= RUN;
                            end else begin
                                rel_idx <= rel_idx + ICW'(1);
                            end
                        end else begin
                            stg_cnt <= stg_cnt + SCW'(1);
                        end
                    end
                    RUN: begin
                        ready_o <= 1'b1;
                    end
                    default: begin
                        state <= HOLD;
                    end
                endcase
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] div_in;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] div_q;
        logic             clk_q;

        assign div_in   = div_i[c*DIV_W +: DIV_W];
        assign clk_o[c] = clk_q;

        // A running high phase always advances; div_q only reloads where the
        // next state is low with cnt=0, so a period in progress is never reshaped.
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                cnt   <= '0;
                div_q <= '0;
                clk_q <= 1'b0;
            end else if (srst_req_i || !rst_n_o[c]) begin
                cnt   <= '0;
                div_q <= div_in;
                clk_q <= 1'b0;
            end else if (clk_en_i[c] || clk_q) begin
                if (cnt == div_q) begin
                    clk_q <= ~clk_q;
                    cnt   <= '0;
                    if (clk_q) begin
                        div_q <= div_in;
                    end
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end else begin
                cnt   <= '0;
                div_q <= div_in;
            end
        end
    end

endmodule

// File: tb/tb_clk_rst_gen.sv
// Bench for clk_rst_gen: reset sequencing, division, gating, divide changes,
// soft and asynchronous reset, plus randomized stimulus against a reference model.
module tb_clk_rst_gen;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 8;
    localparam int HOLD_CYC    = 16;
    localparam int STAGGER_CYC = 4;
    localparam int SYNC_STAGES = 2;

    logic                    clk = 1'b0;
    logic                    arst_n;
    logic [NUM_CH-1:0]       clk_en_i;
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic                    srst_req_i;
    logic [NUM_CH-1:0]       clk_o;
    logic [NUM_CH-1:0]       rst_n_o;
    logic                    ready_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: sequencing is tracked as edges elapsed since E,
    // each divider as edges remaining in its current phase.
    int                sync_age;
    bit                started;
    int                since_e;
    logic [NUM_CH-1:0] m_rst;
    logic [NUM_CH-1:0] m_clk;
    logic              m_ready;
    int                m_left [NUM_CH];
    int                m_pd   [NUM_CH];

    clk_rst_gen #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .HOLD_CYC   (HOLD_CYC),
        .STAGGER_CYC(STAGGER_CYC),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .clk_en_i  (clk_en_i),
        .div_i     (div_i),
        .srst_req_i(srst_req_i),
        .clk_o     (clk_o),
        .rst_n_o   (rst_n_o),
        .ready_o   (ready_o)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        sync_age = 0;
        started  = 1'b0;
        since_e  = 0;
        m_rst    = '0;
        m_clk    = '0;
        m_ready  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_left[c] = 1;
            m_pd[c]   = 0;
        end
    endtask

    // Advance one clock edge, updating the model from inputs sampled at the edge.
    task automatic tick();
        logic                    a;
        logic                    s;
        logic [NUM_CH-1:0]       en;
        logic [NUM_CH*DIV_W-1:0] dv;
        int                      d;
        a  = arst_n;
        s  = srst_req_i;
        en = clk_en_i;
        dv = div_i;
        @(posedge clk);
        if (a) begin
            for (int c = 0; c < NUM_CH; c++) begin
                d = int'(dv[c*DIV_W +: DIV_W]);
                if (s || !m_rst[c]) begin
                    m_clk[c]  = 1'b0;
                    m_pd[c]   = d;
                    m_left[c] = d + 1;
                end else if (!m_clk[c] && !en[c]) begin
                    m_pd[c]   = d;
                    m_left[c] = d + 1;
                end else begin
                    m_left[c]--;
                    if (m_left[c] == 0) begin
                        if (m_clk[c]) m_pd[c] = d;
                        m_clk[c]  = ~m_clk[c];
                        m_left[c] = m_pd[c] + 1;
                    end
                end
            end
            if (sync_age < SYNC_STAGES) sync_age++;
            if (s) started = 1'b0;
            else if (started) since_e++;
            else if (sync_age >= SYNC_STAGES) begin
                started = 1'b1;
                since_e = 0;
            end
            for (int k = 0; k < NUM_CH; k++)
                m_rst[k] = started && (since_e >= HOLD_CYC + k * STAGGER_CYC);
            m_ready = started && (since_e >= HOLD_CYC + (NUM_CH - 1) * STAGGER_CYC + 1);
        end
        #1;
    endtask

    task automatic set_div(input int c, input int v);
        div_i[c*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    task automatic test_reset();
        logic [4:0] want;
        arst_n     = 1'b0;
        srst_req_i = 1'b0;
        clk_en_i   = '1;
        div_i      = {8'd3, 8'd2, 8'd1, 8'd0};
        model_clear();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({ready_o, rst_n_o, clk_o} !== 9'b0)
                $display("FAIL reset_hold: got %b want %b", {ready_o, rst_n_o, clk_o}, 9'b0);
            else n_pass++;
        end
        arst_n = 1'b1;
        for (int n = 1; n <= 35; n++) begin
            tick();
            n_checks++;
            if ({ready_o, rst_n_o, clk_o} !== {m_ready, m_rst, m_clk})
                $display("FAIL reset_seq edge %0d: got %b want %b", n,
                         {ready_o, rst_n_o, clk_o}, {m_ready, m_rst, m_clk});
            else n_pass++;
            if (n == 17 || n == 18 || n == 22 || n == 30 || n == 31) begin
                case (n)
                    17:      want = 5'b00000;
                    18:      want = 5'b00001;
                    22:      want = 5'b00011;
                    30:      want = 5'b01111;
                    default: want = 5'b11111;
                endcase
                n_checks++;
                if ({ready_o, rst_n_o} !== want)
                    $display("FAIL reset_release edge %0d: got %b want %b", n, {ready_o, rst_n_o}, want);
                else n_pass++;
            end
        end
    endtask

    task automatic test_divide();
        int hi [NUM_CH];
        for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++) if (clk_o[c] === 1'b1) hi[c]++;
            n_checks++;
            if ({ready_o, rst_n_o, clk_o} !== {m_ready, m_rst, m_clk})
                $display("FAIL divide_cyc: got %b want %b", {ready_o, rst_n_o, clk_o}, {m_ready, m_rst, m_clk});
            else n_pass++;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            n_checks++;
            if (hi[c] !== 24) $display("FAIL divide_duty ch%0d: got %0d high cycles want 24", c, hi[c]);
            else n_pass++;
        end
    endtask

    task automatic test_gating();
        int   hi_len;
        int   k;
        logic prev;
        set_div(1, 2);
        for (int i = 0; i < 8; i++) tick();
        prev = clk_o[1];
        k = 0;
        while (!(prev == 1'b0 && clk_o[1] == 1'b1) && k < 20) begin
            prev = clk_o[1];
            tick();
            k++;
        end
        hi_len = (clk_o[1] === 1'b1) ? 1 : 0;
        tick();
        if (clk_o[1] === 1'b1) hi_len++;
        clk_en_i[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (clk_o[1] === 1'b1) hi_len++;
            n_checks++;
            if ({ready_o, rst_n_o, clk_o} !== {m_ready, m_rst, m_clk})
                $display("FAIL gate_cyc: got %b want %b", {ready_o, rst_n_o, clk_o}, {m_ready, m_rst, m_clk});
            else n_pass++;
        end
        n_checks++;
        if (hi_len !== 3) $display("FAIL gate_high_len: got %0d want 3", hi_len);
        else n_pass++;
        clk_en_i[1] = 1'b1;
        k = 0;
        while (clk_o[1] !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        n_checks++;
        if (k !== 3) $display("FAIL gate_reenable: first rise on enabled edge %0d want 3", k);
        else n_pass++;
    endtask

    task automatic test_div_change();
        logic [9:0] seen;
        logic [9:0] want;
        int         k;
        logic       prev;
        want = 10'b1110011001;
        set_div(0, 5);
        for (int i = 0; i < 14; i++) tick();
        prev = clk_o[0];
        k = 0;
        while (!(prev == 1'b0 && clk_o[0] == 1'b1) && k < 30) begin
            prev = clk_o[0];
            tick();
            k++;
        end
        tick();
        tick();
        set_div(0, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            seen[9-i] = clk_o[0];
            n_checks++;
            if ({ready_o, rst_n_o, clk_o} !== {m_ready, m_rst, m_clk})
                $display("FAIL divchg_cyc: got %b want %b", {ready_o, rst_n_o, clk_o}, {m_ready, m_rst, m_clk});
            else n_pass++;
        end
        n_checks++;
        if (seen !== want) $display("FAIL divchg_pattern: got %b want %b", seen, want);
        else n_pass++;
    endtask

    task automatic test_soft_reset();
        int rise_n;
        n_checks++;
        if (ready_o !== 1'b1) $display("FAIL srst_pre_ready: got %b want 1", ready_o);
        else n_pass++;
        srst_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({ready_o, rst_n_o, clk_o} !== 9'b0)
                $display("FAIL srst_clear: got %b want %b", {ready_o, rst_n_o, clk_o}, 9'b0);
            else n_pass++;
        end
        srst_req_i = 1'b0;
        rise_n = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (rise_n < 0 && rst_n_o[0] === 1'b1) rise_n = n;
            n_checks++;
            if ({ready_o, rst_n_o, clk_o} !== {m_ready, m_rst, m_clk})
                $display("FAIL srst_seq: got %b want %b", {ready_o, rst_n_o, clk_o}, {m_ready, m_rst, m_clk});
            else n_pass++;
        end
        n_checks++;
        if (rise_n - 1 !== 16) $display("FAIL srst_release0: rose %0d cycles after release want 16", rise_n - 1);
        else n_pass++;
        n_checks++;
        if (ready_o !== 1'b1) $display("FAIL srst_ready: got %b want 1", ready_o);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                clk_en_i[c] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) set_div(c, int'($urandom_range(0, 3)));
            end
            srst_req_i = ($urandom_range(0, 49) == 0);
            tick();
            n_checks++;
            if ({ready_o, rst_n_o, clk_o} !== {m_ready, m_rst, m_clk})
                $display("FAIL random_cyc %0d: got %b want %b", i,
                         {ready_o, rst_n_o, clk_o}, {m_ready, m_rst, m_clk});
            else n_pass++;
        end
        srst_req_i = 1'b0;
        clk_en_i   = '1;
    endtask

    task automatic test_async_mid_release();
        int k;
        int rise_n;
        srst_req_i = 1'b1;
        tick();
        srst_req_i = 1'b0;
        k = 0;
        while (rst_n_o !== 4'b0011 && k < 40) begin
            tick();
            k++;
        end
        n_checks++;
        if (rst_n_o !== 4'b0011) $display("FAIL async_reach_rel: got %b want 0011", rst_n_o);
        else n_pass++;
        #3;
        arst_n = 1'b0;
        #1;
        n_checks++;
        if ({ready_o, rst_n_o, clk_o} !== 9'b0)
            $display("FAIL async_clear: got %b want %b", {ready_o, rst_n_o, clk_o}, 9'b0);
        else n_pass++;
        model_clear();
        for (int i = 0; i < 3; i++) tick();
        arst_n = 1'b1;
        rise_n = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (rise_n < 0 && rst_n_o[0] === 1'b1) rise_n = n;
            n_checks++;
            if ({ready_o, rst_n_o, clk_o} !== {m_ready, m_rst, m_clk})
                $display("FAIL async_seq: got %b want %b", {ready_o, rst_n_o, clk_o}, {m_ready, m_rst, m_clk});
            else n_pass++;
        end
        n_checks++;
        if (rise_n !== 18) $display("FAIL async_release0: edge %0d want 18", rise_n);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_divide();
        test_gating();
        test_div_change();
        test_soft_reset();
        test_random();
        test_async_mid_release();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
